gen_consumer: RTL and testbench
===============================

// Module: gen_consumer
// PURPOSE
//  Consumer-side endpoint for generated generator modules. Launches a producer run with a gen_start pulse.
//  Accepts each yielded value under the producer's ready/valid/done protocol and buffers it in a FIFO.
//  Re-presents the values downstream as a ready/valid stream.
//  Sits between any generated generator module and downstream logic; replaces the bench-style consumer in hardware.
// PARAMETERS
//  WIDTH  32  signed data width of producer output and downstream data
//  DEPTH  8   FIFO entries (power of 2, >=2)
//  CNT_W  16  width of yield counter
// PORTS
//  __clock       in   1      single clock, all state on posedge
//  __reset       in   1      asynchronous, active-high reset
//  __start       in   1      launch request; sampled only in IDLE
//  __done        out  1      one-cycle pulse: producer finished and FIFO drained
//  gen_start     out  1      one-cycle launch pulse to producer __start
//  gen_ready     out  1      to producer __ready; consumer accepts this cycle
//  gen_valid     in   1      producer __valid
//  gen_done      in   1      producer __done
//  gen_output_0  in   WIDTH  producer __output_0 (signed)
//  __valid       out  1      downstream data valid (FIFO non-empty)
//  __ready       in   1      downstream accepts
//  __output_0    out  WIDTH  downstream data, FIFO head (first-word fall-through)
//  count         out  CNT_W  yields captured in current run, saturating
// BEHAVIOUR
//  Reset (async, any time, mid-run included):
//   - state=IDLE; FIFO empty, pointers 0; count=0.
//   - __done=0, gen_start=0, gen_ready=0, __valid=0, __output_0=0.
//   - Producer shares __reset; no partial run survives.
//  FSM IDLE -> LAUNCH -> RUN -> DRAIN -> FIN -> IDLE:
//   - IDLE: __start=1 -> LAUNCH; count cleared on this transition.
//   - LAUNCH: gen_start=1 for exactly one cycle -> RUN.
//   - RUN: gen_ready = !full (combinational from registered occupancy).
//   - RUN, posedge with gen_ready=1:
//       gen_valid=1 -> push gen_output_0, count+1 (saturate at 2^CNT_W-1);
//       gen_done=1  -> DRAIN.
//     Valid and done in the same cycle: push the final value AND go to DRAIN.
//   - RUN, gen_ready=0: gen_valid/gen_done ignored; producer holds (its protocol).
//   - DRAIN: gen_ready=0; when FIFO empty -> FIN.
//   - FIN: __done=1 one cycle -> IDLE.
//  __start outside IDLE is ignored (no queueing).
//  Latency:
//   - __start high at edge k -> gen_start high in cycle k+1.
//   - First producer value accepted at edge t -> __valid high in cycle t+1.
//  FIFO:
//   - Pop on __valid && __ready; push and pop together when non-empty leaves occupancy unchanged.
//   - Full: gen_ready=0 even if a pop occurs that cycle (no full bypass); one-cycle bubble accepted.
//   - Empty: __valid=0; __output_0 holds last value, don't-care.
//   - Pointers log2(DEPTH) bits, natural wrap; occupancy log2(DEPTH)+1 bits.
//  Data passes unmodified, no sign/width conversion; count never wraps.
// STRUCTURE
//  gen_pkg: state enum (IDLE, LAUNCH, RUN, DRAIN, FIN) and default WIDTH=32 constant.
//   Shared with future generator wrappers.
//  Sub-module gen_sync_fifo (WIDTH, DEPTH):
//   - ports push, push_data, pop, head, full, empty, level; FWFT.
//   - Top instantiates it plus the FSM and counter.
// TESTING
//  Producer model: odd-Fibonacci generator, n=40.
//  1. Reset, __start pulse, __ready=1:
//     -> gen_start one cycle later; downstream 1,1,3,5,13,21; count=6; __done one pulse, then IDLE.
//  2. Same run, __ready=0 throughout:
//     -> 8-deep FIFO never fills with 6 values.
//     Repeat DEPTH=4: gen_ready drops after 4 pushes, producer stalls.
//     Raising __ready delivers all 6 in order; no loss or duplicate.
//  3. Producer asserts gen_valid and gen_done together on value 21:
//     -> 21 captured, count=6, DRAIN then __done.
//  4. __start pulsed during RUN -> ignored; no second gen_start; output sequence unchanged.
//  5. __reset asserted mid-run after 3 values:
//     -> all outputs 0 immediately (async), count=0, FIFO empty.
//     A new __start yields the full 6-value sequence again.
//  6. DEPTH=4 full, simultaneous pop:
//     -> gen_ready stays 0 that cycle, rises the next.
//     Occupancy 4->3 on pop; pointers wrap cleanly over 3 back-to-back runs.

Source files
------------

// File: rtl/gen_pkg.sv
// Shared definitions for generator endpoints: controller state codes and default data width.
package gen_pkg;

    localparam int unsigned GEN_WIDTH = 32;

    typedef logic [2:0] gen_state_t;

    localparam gen_state_t ST_IDLE   = 3'd0;
    localparam gen_state_t ST_LAUNCH = 3'd1;
    localparam gen_state_t ST_RUN    = 3'd2;
    localparam gen_state_t ST_DRAIN  = 3'd3;
    localparam gen_state_t ST_FIN    = 3'd4;

endpackage

// File: rtl/gen_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head shows the oldest entry whenever non-empty.
module gen_sync_fifo
    import gen_pkg::*;
#(
    parameter int unsigned WIDTH = GEN_WIDTH,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push_en;
    logic             pop_en;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/gen_consumer.sv
// Consumer endpoint: launches a generator run, buffers its yields and re-streams them downstream.
module gen_consumer
    import gen_pkg::*;
#(
    parameter int unsigned WIDTH = GEN_WIDTH,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             __clock,
    input  logic             __reset,
    input  logic             __start,
    output logic             __done,
    output logic             gen_start,
    output logic             gen_ready,
    input  logic             gen_valid,
    input  logic             gen_done,
    input  logic [WIDTH-1:0] gen_output_0,
    output logic             __valid,
    input  logic             __ready,
    output logic [WIDTH-1:0] __output_0,
    output logic [CNT_W-1:0] count
);

    gen_state_t          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                push;
    logic                pop;

    // Ready depends only on registered occupancy, so a full FIFO stalls even when popping.
    assign gen_ready = (state_q == ST_RUN) && !fifo_full;
    assign gen_start = (state_q == ST_LAUNCH);
    assign __done    = (state_q == ST_FIN);
    assign __valid   = !fifo_empty;
    assign push      = gen_ready && gen_valid;
    assign pop       = __valid && __ready;
    assign count     = count_q;

    gen_sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (__clock),
        .rst       (__reset),
        .push      (push),
        .push_data (gen_output_0),
        .pop       (pop),
        .head      (__output_0),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (__start) begin
                    state_d = ST_LAUNCH;
                    count_d = '0;
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                if (gen_ready && gen_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_level == '0) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (push && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge __clock or posedge __reset) begin
        if (__reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_gen_consumer.sv
// Bench: two consumers (8-deep and 4-deep) fed by odd-Fibonacci producer models, checked against a queue model.
module tb_gen_consumer;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic dready;
    logic combined;

    int fib [6] = '{1, 1, 3, 5, 13, 21};

    always #5 clk = ~clk;

    task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0d expected %0d at %0t", name, lane, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int D = (g == 0) ? 8 : 4;

        logic        g_start_w, g_ready_w, g_valid_w, g_done_w;
        logic        d_valid_w, d_done_w;
        logic [31:0] g_data_w, d_data_w;
        logic [15:0] d_cnt_w;

        gen_consumer #(
            .WIDTH(32),
            .DEPTH(D),
            .CNT_W(16)
        ) dut (
            .__clock      (clk),
            .__reset      (rst),
            .__start      (start),
            .__done       (d_done_w),
            .gen_start    (g_start_w),
            .gen_ready    (g_ready_w),
            .gen_valid    (g_valid_w),
            .gen_done     (g_done_w),
            .gen_output_0 (g_data_w),
            .__valid      (d_valid_w),
            .__ready      (dready),
            .__output_0   (d_data_w),
            .count        (d_cnt_w)
        );

        // producer: yields the odd Fibonacci numbers up to 40, holding under !ready
        int   p_idx;
        logic p_act;
        assign g_valid_w = p_act && (p_idx < 6);
        assign g_done_w  = p_act && (combined ? (p_idx == 5) : (p_idx == 6));
        assign g_data_w  = (p_idx < 6) ? 32'(fib[p_idx]) : '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                p_act <= 1'b0;
                p_idx <= 0;
            end else if (g_start_w) begin
                p_act <= 1'b1;
                p_idx <= 0;
            end else if (p_act && g_ready_w) begin
                if (g_done_w) p_act <= 1'b0;
                else if (g_valid_w) p_idx <= p_idx + 1;
            end
        end

        // reference: phase number plus a queue holding buffered values
        logic [31:0] mq [$];
        int          ph;
        int          mcnt;
        int          sz;
        bit          acc;
        bit          mpop;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mq.delete();
                ph   = 0;
                mcnt = 0;
            end else begin
                sz   = mq.size();
                acc  = (ph == 2) && (sz < D);
                mpop = (sz > 0) && dready;
                case (ph)
                    0: if (start) begin ph = 1; mcnt = 0; end
                    1: ph = 2;
                    2: if (acc && g_done_w) ph = 3;
                    3: if (sz == 0) ph = 4;
                    default: ph = 0;
                endcase
                if (mpop) void'(mq.pop_front());
                if (acc && g_valid_w) begin
                    mq.push_back(g_data_w);
                    if (mcnt < 65535) mcnt++;
                end
            end
        end

        logic [31:0] rx [256];
        int rx_n   = 0;
        int done_n = 0;

        always @(negedge clk) begin
            if (!rst) begin
                chk("gen_start", g, 32'(g_start_w), 32'(ph == 1));
                chk("gen_ready", g, 32'(g_ready_w), 32'((ph == 2) && (mq.size() < D)));
                chk("done", g, 32'(d_done_w), 32'(ph == 4));
                chk("valid", g, 32'(d_valid_w), 32'(mq.size() > 0));
                if (mq.size() > 0) chk("data", g, d_data_w, mq[0]);
                chk("count", g, 32'(d_cnt_w), 32'(mcnt));
                if (d_done_w) done_n++;
                if (d_valid_w && dready && rx_n < 256) begin
                    rx[rx_n] = d_data_w;
                    rx_n++;
                end
            end
        end
    end

    task automatic chk_seq(input string tag, input int l, input logic [31:0] arr [256],
                           input int base, input int n, input logic [15:0] cnt);
        chk({tag, "_len"}, l, 32'(n - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < 256) chk({tag, "_val"}, l, arr[base + i], 32'(fib[i]));
        end
        chk({tag, "_count"}, l, 32'(cnt), 32'd6);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, 0, 32'(lane[0].g_start_w), 32'd0);
        chk({tag, "_ready"}, 0, 32'(lane[0].g_ready_w), 32'd0);
        chk({tag, "_done"},  0, 32'(lane[0].d_done_w),  32'd0);
        chk({tag, "_valid"}, 0, 32'(lane[0].d_valid_w), 32'd0);
        chk({tag, "_data"},  0, lane[0].d_data_w,       32'd0);
        chk({tag, "_count"}, 0, 32'(lane[0].d_cnt_w),   32'd0);
        chk({tag, "_start"}, 1, 32'(lane[1].g_start_w), 32'd0);
        chk({tag, "_ready"}, 1, 32'(lane[1].g_ready_w), 32'd0);
        chk({tag, "_done"},  1, 32'(lane[1].d_done_w),  32'd0);
        chk({tag, "_valid"}, 1, 32'(lane[1].d_valid_w), 32'd0);
        chk({tag, "_data"},  1, lane[1].d_data_w,       32'd0);
        chk({tag, "_count"}, 1, 32'(lane[1].d_cnt_w),   32'd0);
    endtask

    task automatic launch();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("launch_pulse", 0, 32'(lane[0].g_start_w), 32'd1);
        chk("launch_pulse", 1, 32'(lane[1].g_start_w), 32'd1);
    endtask

    task automatic do_run(input string tag, input int stall, input bit mid_start);
        int b0, b1, dn0, dn1, cyc;
        b0  = lane[0].rx_n;
        b1  = lane[1].rx_n;
        dn0 = lane[0].done_n;
        dn1 = lane[1].done_n;
        dready = (stall == 0);
        launch();
        if (mid_start) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            chk({tag, "_stall_count"}, 0, 32'(lane[0].d_cnt_w), 32'd6);
            chk({tag, "_stall_count"}, 1, 32'(lane[1].d_cnt_w), 32'd4);
            chk({tag, "_stall_valid"}, 0, 32'(lane[0].d_valid_w), 32'd1);
            dready = 1'b1;
            #1 chk({tag, "_full_pop_ready"}, 1, 32'(lane[1].g_ready_w), 32'd0);
            @(posedge clk); #1;
            chk({tag, "_after_pop_ready"}, 1, 32'(lane[1].g_ready_w), 32'd1);
        end
        cyc = 0;
        while ((lane[0].done_n == dn0 || lane[1].done_n == dn1) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_finished"}, 0, 32'(lane[0].done_n - dn0), 32'd1);
        chk({tag, "_finished"}, 1, 32'(lane[1].done_n - dn1), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_one_done"}, 0, 32'(lane[0].done_n - dn0), 32'd1);
        chk_seq(tag, 0, lane[0].rx, b0, lane[0].rx_n, lane[0].d_cnt_w);
        chk_seq(tag, 1, lane[1].rx, b1, lane[1].rx_n, lane[1].d_cnt_w);
    endtask

    initial begin
        int cyc;
        rst      = 1'b0;
        start    = 1'b0;
        dready   = 1'b1;
        combined = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;

        do_run("basic", 0, 1'b0);
        do_run("backpressure", 20, 1'b0);
        combined = 1'b1;
        do_run("valid_with_done", 0, 1'b0);
        combined = 1'b0;
        do_run("ignored_start", 0, 1'b1);

        // asynchronous reset in the middle of a run
        dready = 1'b1;
        launch();
        cyc = 0;
        while (lane[0].d_cnt_w != 16'd3 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_reset_reached3", 0, 32'(lane[0].d_cnt_w), 32'd3);
        #2 rst = 1'b1;
        #1 chk_zero("mid_reset");
        @(posedge clk); #1 rst = 1'b0;
        do_run("after_reset", 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            do_run("wrap", 20, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
